// File: rtl/usr_pkg.sv
// -----------------------------------------------------------------------------
// usr_pkg
// Shared definitions for the universal shift register and its bit slices.
//   MODE_HOLD / MODE_SHR / MODE_SHL / MODE_LOAD : 2-bit operation mode codes.
//   is_shift() : true for the two shift modes (used by the shift counter).
// -----------------------------------------------------------------------------
package usr_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  function automatic logic is_shift(input logic [1:0] mode);
    return (mode == MODE_SHR) || (mode == MODE_SHL);
  endfunction

endpackage : usr_pkg

// File: rtl/usr_bit_slice.sv
// -----------------------------------------------------------------------------
// usr_bit_slice
// One bit of the universal shift register: a flip-flop with asynchronous clear,
// a synchronous preset override and a 4:1 next-state mux.
// Ports:
//   iClk    rising-edge clock
//   iClr    asynchronous active-high clear (bit -> 0)
//   iPre    synchronous preset (bit -> 1), beats enable and mode
//   iEnb    operation enable; low holds the bit
//   iMode   2-bit mode (hold / shift right / shift left / load)
//   iLeft   value of the next-higher bit (enters on shift right)
//   iRight  value of the next-lower bit (enters on shift left)
//   iD      parallel load bit
//   oQ      stored bit
// -----------------------------------------------------------------------------
module usr_bit_slice
  import usr_pkg::*;
(
  input  logic       iClk,
  input  logic       iClr,
  input  logic       iPre,
  input  logic       iEnb,
  input  logic [1:0] iMode,
  input  logic       iLeft,
  input  logic       iRight,
  input  logic       iD,
  output logic       oQ
);

  logic r_q;

  always_ff @(posedge iClk or posedge iClr) begin
    if (iClr) begin
      r_q <= 1'b0;
    end else if (iPre) begin
      r_q <= 1'b1;
    end else if (iEnb) begin
      case (iMode)
        MODE_SHR:  r_q <= iLeft;
        MODE_SHL:  r_q <= iRight;
        MODE_LOAD: r_q <= iD;
        default:   r_q <= r_q;
      endcase
    end
  end

  assign oQ = r_q;

endmodule : usr_bit_slice

// File: rtl/universal_shift_reg.sv
// -----------------------------------------------------------------------------
// universal_shift_reg
// Parametrised universal shift register (hold / shift right / shift left /
// parallel load) with a saturating shift counter and an exhausted flag, usable
// directly as a parallel-to-serial converter.
// Optional feature macro: USR_ROTATE_EN adds iRot; when high, shifts rotate
// (the bit leaving one end re-enters at the other) instead of using the serial
// inputs.
// Parameters:
//   WIDTH      register width (>= 2)
//   CNT_W      shift-counter width, derived from WIDTH
// Ports:
//   iClk       rising-edge clock
//   iClr       asynchronous active-high clear
//   iPre       synchronous preset to all ones (clears the counter)
//   iEnb       operation enable
//   iMode      00 hold, 01 shift right, 10 shift left, 11 load
//   iD         parallel load data
//   iSerR      serial input entering at MSB on shift right
//   iSerL      serial input entering at LSB on shift left
//   iRot       (USR_ROTATE_EN only) rotate instead of serial input
//   oQp        register contents
//   oQn        bitwise complement of oQp
//   oSerOutR   oQp[0]
//   oSerOutL   oQp[WIDTH-1]
//   oShiftCnt  shifts since last load/preset/clear, saturating at WIDTH
//   oEmpty     high when oShiftCnt == WIDTH
// -----------------------------------------------------------------------------
module universal_shift_reg
  import usr_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             iClk,
  input  logic             iClr,
  input  logic             iPre,
  input  logic             iEnb,
  input  logic [1:0]       iMode,
  input  logic [WIDTH-1:0] iD,
  input  logic             iSerR,
  input  logic             iSerL,
`ifdef USR_ROTATE_EN
  input  logic             iRot,
`endif
  output logic [WIDTH-1:0] oQp,
  output logic [WIDTH-1:0] oQn,
  output logic             oSerOutR,
  output logic             oSerOutL,
  output logic [CNT_W-1:0] oShiftCnt,
  output logic             oEmpty
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_from_left;   // source bit for each position on shift right
  logic [WIDTH-1:0] w_from_right;  // source bit for each position on shift left
  logic             w_msb_in;
  logic             w_lsb_in;
  logic             w_full;
  logic [CNT_W-1:0] r_cnt;

  // End-of-register inputs: serial pins, or the opposite end when rotating.
`ifdef USR_ROTATE_EN
  assign w_msb_in = iRot ? w_q[0]       : iSerR;
  assign w_lsb_in = iRot ? w_q[WIDTH-1] : iSerL;
`else
  assign w_msb_in = iSerR;
  assign w_lsb_in = iSerL;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_slice
      if (gi == WIDTH - 1) begin : g_msb
        assign w_from_left[gi] = w_msb_in;
      end else begin : g_mid_l
        assign w_from_left[gi] = w_q[gi+1];
      end

      if (gi == 0) begin : g_lsb
        assign w_from_right[gi] = w_lsb_in;
      end else begin : g_mid_r
        assign w_from_right[gi] = w_q[gi-1];
      end

      usr_bit_slice u_bit (
        .iClk   (iClk),
        .iClr   (iClr),
        .iPre   (iPre),
        .iEnb   (iEnb),
        .iMode  (iMode),
        .iLeft  (w_from_left[gi]),
        .iRight (w_from_right[gi]),
        .iD     (iD[gi]),
        .oQ     (w_q[gi])
      );
    end
  endgenerate

  assign w_full = (r_cnt == CNT_FULL);

  // Shift counter: same priority chain as the data bits; stops at WIDTH while
  // the data keeps shifting.
  always_ff @(posedge iClk or posedge iClr) begin
    if (iClr) begin
      r_cnt <= '0;
    end else if (iPre) begin
      r_cnt <= '0;
    end else if (iEnb) begin
      if (iMode == MODE_LOAD) begin
        r_cnt <= '0;
      end else if (is_shift(iMode) && !w_full) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign oQp       = w_q;
  assign oQn       = ~w_q;
  assign oSerOutR  = w_q[0];
  assign oSerOutL  = w_q[WIDTH-1];
  assign oShiftCnt = r_cnt;
  assign oEmpty    = w_full;

endmodule : universal_shift_reg

// File: tb/tb_universal_shift_reg.sv
module tb_universal_shift_reg;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             iClk = 1'b0;
  logic             iClr;
  logic             iPre;
  logic             iEnb;
  logic [1:0]       iMode;
  logic [WIDTH-1:0] iD;
  logic             iSerR;
  logic             iSerL;
`ifdef USR_ROTATE_EN
  logic             iRot;
`endif
  logic [WIDTH-1:0] oQp;
  logic [WIDTH-1:0] oQn;
  logic             oSerOutR;
  logic             oSerOutL;
  logic [CNT_W-1:0] oShiftCnt;
  logic             oEmpty;

  int n_total = 0;
  int n_bad   = 0;

  universal_shift_reg #(.WIDTH(WIDTH)) dut (
    .iClk      (iClk),
    .iClr      (iClr),
    .iPre      (iPre),
    .iEnb      (iEnb),
    .iMode     (iMode),
    .iD        (iD),
    .iSerR     (iSerR),
    .iSerL     (iSerL),
`ifdef USR_ROTATE_EN
    .iRot      (iRot),
`endif
    .oQp       (oQp),
    .oQn       (oQn),
    .oSerOutR  (oSerOutR),
    .oSerOutL  (oSerOutL),
    .oShiftCnt (oShiftCnt),
    .oEmpty    (oEmpty)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance one rising edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic do_op(input logic [1:0] mode, input logic [WIDTH-1:0] d,
                       input logic ser_r, input logic ser_l);
    iMode = mode;
    iD    = d;
    iSerR = ser_r;
    iSerL = ser_l;
    step();
  endtask

  logic [WIDTH-1:0] pattern;

  initial begin
    iClr = 1'b1; iPre = 1'b0; iEnb = 1'b1; iMode = 2'b00;
    iD = '0; iSerR = 1'b0; iSerL = 1'b0;
`ifdef USR_ROTATE_EN
    iRot = 1'b0;
`endif
    step();
    step();
    chk("reset_qp",    32'(oQp), 32'h00);
    chk("reset_qn",    32'(oQn), 32'hFF);
    chk("reset_cnt",   32'(oShiftCnt), 0);
    chk("reset_empty", 32'(oEmpty), 0);
    iClr = 1'b0;

    // Load A5 then clear asynchronously mid-cycle.
    do_op(2'b11, 8'hA5, 1'b0, 1'b0);
    chk("load_a5", 32'(oQp), 32'hA5);
    iMode = 2'b01;
    do_op(2'b01, 8'h00, 1'b1, 1'b0);  // one shift so the counter is nonzero
    chk("shr_a5_qp",  32'(oQp), 32'hD2);
    chk("shr_a5_cnt", 32'(oShiftCnt), 1);
    #2 iClr = 1'b1;
    #1;
    chk("async_clr_qp",  32'(oQp), 32'h00);
    chk("async_clr_qn",  32'(oQn), 32'hFF);
    chk("async_clr_cnt", 32'(oShiftCnt), 0);
    step();  // clock ignored while clear held, even with a shift mode
    chk("clr_held_qp", 32'(oQp), 32'h00);
    iClr = 1'b0;

    // Load B4 and shift out all 8 bits to the right.
    do_op(2'b11, 8'hB4, 1'b0, 1'b0);
    chk("load_b4_qp",  32'(oQp), 32'hB4);
    chk("load_b4_cnt", 32'(oShiftCnt), 0);
    pattern = 8'hB4;
    for (int k = 0; k < WIDTH; k++) begin
      chk($sformatf("serout_r_%0d", k), 32'(oSerOutR), 32'(pattern[k]));
      chk($sformatf("cnt_before_%0d", k), 32'(oShiftCnt), k);
      chk($sformatf("empty_before_%0d", k), 32'(oEmpty), 0);
      do_op(2'b01, 8'h00, 1'b0, 1'b0);
    end
    chk("shr8_qp",    32'(oQp), 32'h00);
    chk("shr8_cnt",   32'(oShiftCnt), 8);
    chk("shr8_empty", 32'(oEmpty), 1);
    do_op(2'b01, 8'h00, 1'b1, 1'b0);  // shifting continues, counter saturates
    chk("shr9_qp",    32'(oQp), 32'h80);
    chk("shr9_cnt",   32'(oShiftCnt), 8);
    chk("shr9_empty", 32'(oEmpty), 1);

    // Load 01, shift left 3 with ones.
    do_op(2'b11, 8'h01, 1'b0, 1'b0);
    chk("load_01_empty", 32'(oEmpty), 0);
    repeat (3) do_op(2'b10, 8'h00, 1'b0, 1'b1);
    chk("shl3_qp",    32'(oQp), 32'h0F);
    chk("shl3_cnt",   32'(oShiftCnt), 3);
    chk("shl3_empty", 32'(oEmpty), 0);
    chk("shl3_serl",  32'(oSerOutL), 0);
    chk("shl3_qn",    32'(oQn), 32'hF0);

    // Preset beats load.
    iPre = 1'b1;
    do_op(2'b11, 8'h3C, 1'b0, 1'b0);
    iPre = 1'b0;
    chk("pre_load_qp",  32'(oQp), 32'hFF);
    chk("pre_load_cnt", 32'(oShiftCnt), 0);

    // Two right shifts with zeros, then enable low for 4 cycles.
    repeat (2) do_op(2'b01, 8'h00, 1'b0, 1'b0);
    chk("shr2_qp",  32'(oQp), 32'h3F);
    chk("shr2_cnt", 32'(oShiftCnt), 2);
    iEnb = 1'b0;
    repeat (4) do_op(2'b01, 8'h00, 1'b1, 1'b1);
    chk("enb_low_qp",  32'(oQp), 32'h3F);
    chk("enb_low_cnt", 32'(oShiftCnt), 2);
    do_op(2'b11, 8'h55, 1'b0, 1'b0);
    chk("enb_low_load_qp", 32'(oQp), 32'h3F);
    iPre = 1'b1;
    do_op(2'b01, 8'h00, 1'b0, 1'b0);  // preset ignores enable
    iPre = 1'b0;
    chk("pre_enb_low_qp",  32'(oQp), 32'hFF);
    chk("pre_enb_low_cnt", 32'(oShiftCnt), 0);
    iEnb = 1'b1;

    // Hold mode keeps data and counter.
    do_op(2'b10, 8'h00, 1'b0, 1'b0);
    chk("shl1_qp", 32'(oQp), 32'hFE);
    repeat (3) do_op(2'b00, 8'h12, 1'b1, 1'b1);
    chk("hold_qp",  32'(oQp), 32'hFE);
    chk("hold_cnt", 32'(oShiftCnt), 1);
    chk("hold_serr", 32'(oSerOutR), 0);
    chk("hold_serl", 32'(oSerOutL), 1);

`ifdef USR_ROTATE_EN
    do_op(2'b11, 8'h81, 1'b0, 1'b0);
    iRot = 1'b1;
    do_op(2'b01, 8'h00, 1'b0, 1'b0);
    chk("rot_r_qp", 32'(oQp), 32'hC0);
    repeat (2) do_op(2'b10, 8'h00, 1'b0, 1'b0);
    chk("rot_l_qp",  32'(oQp), 32'h03);
    chk("rot_l_cnt", 32'(oShiftCnt), 3);
    iRot = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_universal_shift_reg
